// File: rtl/monitor_clk_sequencer_if.sv
// Avalon-MM slave bus for the monitor clock sequencer: 2-bit register select, write strobe, 32-bit data.
interface monitor_clk_sequencer_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/monitor_clk_sequencer.sv
// Stepping-clock generator: emits COUNT clean pulses of (div+1)-cycle half-period after a software start.
// Define MONITOR_CLKSEQ_IRQ_EN to add the registered completion interrupt port irq.
module monitor_clk_sequencer #(
   parameter int CNT_W = 16,
   parameter int DIV_W = 8
) (
   input  logic                   clk,
   input  logic                   reset_n,
   monitor_clk_sequencer_if.slave bus,
   output logic                   out_port
`ifdef MONITOR_CLKSEQ_IRQ_EN
   ,
   output logic                   irq
`endif
);

   typedef enum logic [1:0] {IDLE, LEAD, HIGH, LOW} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [DIV_W-1:0] div, div_nxt;
   logic [DIV_W-1:0] tmr, tmr_nxt;
   logic             done, done_nxt;
   logic             out_nxt;

   logic wr;
   logic wr_level, wr_count, wr_div;
   logic start, abort, clr;
   logic busy;
   logic phase_end;
   logic unused_wdata;

   assign wr       = bus.chipselect && !bus.write_n;
   assign wr_level = wr && (bus.address == 2'd0);
   assign wr_count = wr && (bus.address == 2'd1);
   assign wr_div   = wr && (bus.address == 2'd2);
   assign start    = wr && (bus.address == 2'd3) && bus.writedata[0];
   assign abort    = wr && (bus.address == 2'd3) && bus.writedata[1];
   assign clr      = wr && (bus.address == 2'd3) && bus.writedata[2];

   assign busy      = (state != IDLE);
   assign phase_end = (tmr == div);

   assign unused_wdata = ^bus.writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count    <= '0;
         div      <= '0;
         tmr      <= '0;
         done     <= 1'b0;
         out_port <= 1'b0;
      end else begin
         count    <= count_nxt;
         div      <= div_nxt;
         tmr      <= tmr_nxt;
         done     <= done_nxt;
         out_port <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      div_nxt   = div;
      tmr_nxt   = tmr;
      done_nxt  = done;
      out_nxt   = out_port;

      // Clear is applied first so that a start or a completion on the same edge takes precedence.
      if (clr) begin
         done_nxt = 1'b0;
      end

      if (state == IDLE) begin
         tmr_nxt = '0;
         if (wr_level) begin
            out_nxt = bus.writedata[0];
         end
         if (wr_count) begin
            count_nxt = bus.writedata[CNT_W-1:0];
         end
         if (wr_div) begin
            div_nxt = bus.writedata[DIV_W-1:0];
         end
         if (start && !abort) begin
            if (count != '0) begin
               state_nxt = LEAD;
               out_nxt   = 1'b0;
               done_nxt  = 1'b0;
            end else begin
               done_nxt = 1'b1;
            end
         end
      end else begin
         tmr_nxt = tmr + 1'b1;
         if (phase_end) begin
            tmr_nxt = '0;
            if (state == LEAD) begin
               state_nxt = HIGH;
               out_nxt   = 1'b1;
            end else if (state == HIGH) begin
               state_nxt = LOW;
               out_nxt   = 1'b0;
               count_nxt = count - 1'b1;
            end else if (count != '0) begin
               state_nxt = HIGH;
               out_nxt   = 1'b1;
            end else begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
      end

      // Abort freezes count and leaves done alone apart from an explicit clear.
      if (abort) begin
         state_nxt = IDLE;
         out_nxt   = 1'b0;
         tmr_nxt   = '0;
         count_nxt = count;
         done_nxt  = done & ~clr;
      end
   end

   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         2'd0:    bus.readdata[0]         = out_port;
         2'd1:    bus.readdata[CNT_W-1:0] = count;
         2'd2:    bus.readdata[DIV_W-1:0] = div;
         default: bus.readdata[1:0]       = {done, busy};
      endcase
   end

`ifdef MONITOR_CLKSEQ_IRQ_EN
   assign irq = done;
`endif

endmodule

// File: tb/tb_monitor_clk_sequencer.sv
// Scoreboard bench for monitor_clk_sequencer: directed register/sequence stimulus, negedge monitor compares.
module tb_monitor_clk_sequencer;

   logic clk;
   logic reset_n;
   logic out_port;
`ifdef MONITOR_CLKSEQ_IRQ_EN
   logic irq;
`endif

   monitor_clk_sequencer_if avs();

   monitor_clk_sequencer #(.CNT_W(16), .DIV_W(8)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (avs),
      .out_port (out_port)
`ifdef MONITOR_CLKSEQ_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  addr;
      logic [31:0] rd;
      logic        out;
   } exp_t;

   exp_t sb[$];
   logic obs_vld;
   int   checks;
   int   failures;

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: compares whatever the DUT presents in any cycle the stimulus marked as observed.
   always @(negedge clk) begin
      if (obs_vld) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_rd"}, avs.readdata, e.rd);
            check({e.name, "_out"}, {31'd0, out_port}, {31'd0, e.out});
`ifdef MONITOR_CLKSEQ_IRQ_EN
            if (e.addr == 2'd3) check({e.name, "_irq"}, {31'd0, irq}, {31'd0, e.rd[1]});
`endif
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(logic [1:0] addr, logic [31:0] data);
      avs.address    = addr;
      avs.writedata  = data;
      avs.chipselect = 1'b1;
      avs.write_n    = 1'b0;
      step();
      avs.chipselect = 1'b0;
      avs.write_n    = 1'b1;
   endtask

   task automatic observe(logic [1:0] addr, logic [31:0] rd, logic out, string name);
      exp_t e;
      e.name = name;
      e.addr = addr;
      e.rd   = rd;
      e.out  = out;
      avs.address = addr;
      sb.push_back(e);
      obs_vld = 1'b1;
      step();
      obs_vld = 1'b0;
   endtask

   // Cycle c=1 is the first cycle after the edge that sampled start; busy lasts d*(2n+1) cycles.
   task automatic run_check(string tag, int first, int last, int d, int n);
      int b;
      b = d * (2 * n + 1);
      for (int c = first; c <= last; c++) begin
         logic        o;
         logic [31:0] rd;
         o  = (c > d && c <= b) ? (((c - d - 1) / d) % 2 == 0) : 1'b0;
         rd = (c <= b) ? 32'd1 : 32'd2;
         observe(2'd3, rd, o, $sformatf("%s_c%0d", tag, c));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks         = 0;
      failures       = 0;
      obs_vld        = 1'b0;
      reset_n        = 1'b0;
      avs.address    = 2'd0;
      avs.chipselect = 1'b0;
      avs.write_n    = 1'b1;
      avs.writedata  = 32'd0;
      repeat (3) step();
      reset_n = 1'b1;
      step();

      // Reset values
      observe(2'd0, 32'd0, 1'b0, "rst_level");
      observe(2'd1, 32'd0, 1'b0, "rst_count");
      observe(2'd2, 32'd0, 1'b0, "rst_div");
      observe(2'd3, 32'd0, 1'b0, "rst_status");

      // Manual level while idle
      write(2'd0, 32'd1);
      observe(2'd0, 32'd1, 1'b1, "level_hi");
      write(2'd0, 32'd0);
      observe(2'd0, 32'd0, 1'b0, "level_lo");

      // DIV=2, COUNT=3: 3 low, then 3 pulses of 3/3, busy 21 cycles
      write(2'd2, 32'd2);
      write(2'd1, 32'd3);
      observe(2'd2, 32'd2, 1'b0, "div_rd");
      write(2'd3, 32'd1);
      run_check("seq3", 1, 23, 3, 3);
      observe(2'd1, 32'd0, 1'b0, "seq3_count");

      // Writes while busy are ignored: DIV=2, COUNT=2 runs 15 cycles regardless
      write(2'd1, 32'd2);
      write(2'd3, 32'd1);
      write(2'd0, 32'd1);
      write(2'd1, 32'd9);
      write(2'd2, 32'd7);
      write(2'd3, 32'd1);
      run_check("busywr", 5, 17, 3, 2);
      observe(2'd1, 32'd0, 1'b0, "busywr_count");
      observe(2'd2, 32'd2, 1'b0, "busywr_div");

      // COUNT=0 start: no pulse, done next cycle, never busy; start beats clear
      write(2'd1, 32'd0);
      write(2'd3, 32'd4);
      observe(2'd3, 32'd0, 1'b0, "clr_done");
      write(2'd3, 32'd5);
      for (int i = 0; i < 3; i++) observe(2'd3, 32'd2, 1'b0, $sformatf("zero_c%0d", i + 1));

      // DIV=0, COUNT=100, abort sampled 50 edges after start
      write(2'd2, 32'd0);
      write(2'd1, 32'd100);
      write(2'd3, 32'd1);
      run_check("fast", 1, 4, 1, 100);
      repeat (45) step();
      write(2'd3, 32'd2);
      observe(2'd3, 32'd0, 1'b0, "abort_status");
      observe(2'd1, 32'd76, 1'b0, "abort_count");

      // Single pulse then clear-done; irq tracks done when present
      write(2'd1, 32'd1);
      write(2'd3, 32'd1);
      run_check("one", 1, 4, 1, 1);
      write(2'd3, 32'd4);
      observe(2'd3, 32'd0, 1'b0, "one_clr");

      // Reset mid-sequence returns everything to reset values
      write(2'd2, 32'd3);
      write(2'd1, 32'd5);
      write(2'd3, 32'd1);
      repeat (10) step();
      reset_n = 1'b0;
      observe(2'd1, 32'd0, 1'b0, "mrst_count");
      observe(2'd3, 32'd0, 1'b0, "mrst_status");
      observe(2'd2, 32'd0, 1'b0, "mrst_div");
      reset_n = 1'b1;
      observe(2'd0, 32'd0, 1'b0, "mrst_level");
      observe(2'd3, 32'd0, 1'b0, "mrst_status2");

      repeat (2) step();
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/monitor_clk_sequencer.md
# monitor_clk_sequencer

Avalon-MM slave in the monitor Qsys system that generates the stepping clock for the tinymips data memory (or core) under software control. It replaces bit-banging a single PIO output: software programs a pulse count and half-period, issues start, and the block emits exactly that many clean clock pulses, then reports completion. A manual level mode is kept for single-edge debugging while idle.

## Interface
- CNT_W, 16, width of the pulse-count register (1..32)
- DIV_W, 8, width of the half-period divider register (1..32)

- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe; write occurs when chipselect && !write_n
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address, unused bits 0
- out_port  out  1  generated clock to the target
- irq  out  1  completion interrupt (only with MONITOR_CLKSEQ_IRQ_EN)

## Operation
- Registers:
  - addr 0 LEVEL: write bit0 sets out_port directly when idle; read bit0 = out_port.
  - addr 1 COUNT: write loads count[CNT_W-1:0] when idle; read = current count (decrements while running).
  - addr 2 DIV: write loads div[DIV_W-1:0] when idle; half-period D = div+1 clk cycles; read = div.
  - addr 3 CTRL/STATUS: write bit0 start, bit1 abort, bit2 clear done; read bit0 busy, bit1 done.
- Writes to LEVEL, COUNT, DIV while busy are ignored.
- FSM states IDLE, LEAD, HIGH, LOW; phase timer counts D cycles per state.
  - IDLE + start, count≠0 -> LEAD (out_port=0, done cleared).
  - IDLE + start, count=0 -> stay IDLE, done set next edge, no pulse.
  - LEAD after D cycles -> HIGH (out_port=1).
  - HIGH after D cycles -> LOW (out_port=0), count decremented on this transition.
  - LOW after D cycles -> HIGH if count≠0, else IDLE with done=1.
  - Any state + abort -> IDLE next edge, out_port=0, count frozen, done unchanged.
- Start while busy ignored. Abort and start in same write: abort wins. Clear done and start in same write: start wins (done cleared anyway by start).
- busy = (state != IDLE).

## Timing
- Reset: out_port=0, state IDLE, count=0, div=0, done=0, busy=0, irq=0.
- Register writes take effect at the edge sampling the write; readdata reflects new value the following cycle.
- Start sampled at edge t: out_port low from t+1 for D cycles; first rising edge of out_port at t+1+D.
- Each pulse: D cycles high, D cycles low; N pulses -> busy for D*(2N+1) cycles, done=1 on the edge busy falls.
- out_port is registered, glitch-free; no phase shorter than D cycles except on abort or reset.
- Reset mid-sequence: immediate return to reset values; count is lost.
- div=0 gives D=1: out_port toggles every cycle (clk/2).

## Configuration
- MONITOR_CLKSEQ_IRQ_EN defined: irq port present, irq = done, registered; cleared by clear-done or start.
- Undefined: no irq port; done only observable via STATUS read.

## Test plan
- Reset -> all registers read 0, out_port=0, busy=0.
- DIV=2, COUNT=3, start -> out_port low 3 cycles, then 3 pulses of 3 high/3 low; busy for 21 cycles; COUNT reads 0; done=1.
- COUNT=0, start -> no out_port edge, done=1 one cycle later, busy never 1.
- DIV=0, COUNT=100, start, abort after 50 cycles -> out_port=0 next cycle, busy=0, done=0, COUNT reads 76.
- While busy, write LEVEL=1, COUNT=9, DIV=7, start -> all ignored, sequence timing unchanged.
- With IRQ_EN: COUNT=1 run -> irq rises with done; write CTRL bit2 -> irq and done 0.
